// File: rtl/bus_serial_pkg.sv
// Shared definitions for the bus_serial console: register offsets, STATUS bit
// positions, the serial FSM encoding shared by TX and RX, and the STATUS packer.
package bus_serial_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_NONEMPTY  = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_TX_DROP      = 4;
  localparam int ST_RX_FRAME_ERR = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } ser_state_e;

  function automatic logic [31:0] pack_status(
    input logic tx_full, input logic tx_empty, input logic rx_nonempty,
    input logic rx_overrun, input logic tx_drop, input logic rx_frame_err
  );
    logic [31:0] s;
    s = '0;
    s[ST_TX_FULL]      = tx_full;
    s[ST_TX_EMPTY]     = tx_empty;
    s[ST_RX_NONEMPTY]  = rx_nonempty;
    s[ST_RX_OVERRUN]   = rx_overrun;
    s[ST_TX_DROP]      = tx_drop;
    s[ST_RX_FRAME_ERR] = rx_frame_err;
    return s;
  endfunction

endpackage

// File: rtl/bus_serial_fifo.sv
// Synchronous FIFO with a combinational head output. A push into a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/bus_serial.sv
// Memory-mapped 8N1 serial console on the core data bus (DATA/STATUS/CTRL).
// Define BUS_SERIAL_LOOPBACK_EN to add CTRL bit0, which routes txd into the receiver.
module bus_serial
  import bus_serial_pkg::*;
#(
  parameter logic [31:0] BASE   = 32'h0000_0020,
  parameter int          CLKDIV = 16,
  parameter int          DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe,
  input  logic        mem_rw,
  input  logic [31:0] d_addr,
  inout  wire  [31:0] d_data,
  input  logic        rxd,
  output logic        txd
);

  localparam int CW = $clog2(CLKDIV);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKDIV / 2 - 1);

  // ---------------- bus decode ----------------
  logic [31:0] offs, rd_data, ctrl_rd;
  logic [1:0]  reg_sel;
  logic        hit, rd_hit, wr_hit, unused_bits;

  assign offs        = d_addr - BASE;
  assign hit         = strobe && (offs < 32'd3);
  assign rd_hit      = hit && !mem_rw;
  assign wr_hit      = hit && mem_rw;
  assign reg_sel     = offs[1:0];
  assign unused_bits = ^d_data[31:8];

  // ---------------- FIFOs ----------------
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head, rx_sh_q, rx_sh_d;

  assign tx_push = wr_hit && (reg_sel == REG_DATA) && !tx_full;
  assign rx_pop  = rd_hit && (reg_sel == REG_DATA) && !rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push_i(tx_push), .pop_i(tx_pop),
    .din_i(d_data[7:0]), .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push_i(rx_push), .pop_i(rx_pop),
    .din_i(rx_sh_q), .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  // ---------------- TX FSM ----------------
  ser_state_e    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d, tx_last;

  assign tx_last = (tx_cnt_q == CNT_LAST);
  assign txd     = txd_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      S_IDLE:  if (!tx_empty) tx_state_d = S_START;
      S_START: if (tx_last) tx_state_d = S_DATA;
      S_DATA:  if (tx_last && tx_bit_q == 3'd7) tx_state_d = S_STOP;
      S_STOP:  if (tx_last) tx_state_d = S_IDLE;
      default: tx_state_d = S_IDLE;
    endcase
  end

  // txd is registered from the next state so the pin never glitches.
  always_comb begin
    tx_pop   = 1'b0;
    tx_cnt_d = tx_last ? '0 : tx_cnt_q + CNT_ONE;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    if (tx_state_q == S_IDLE) begin
      tx_cnt_d = '0;
      tx_bit_d = '0;
      if (!tx_empty) begin
        tx_pop  = 1'b1;
        tx_sh_d = tx_head;
      end
    end else if (tx_state_q == S_DATA && tx_last) begin
      tx_bit_d = tx_bit_q + 3'd1;
      tx_sh_d  = {1'b0, tx_sh_q[7:1]};
    end
    unique case (tx_state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // ---------------- RX input select ----------------
  logic rx_in;
`ifdef BUS_SERIAL_LOOPBACK_EN
  logic lb_q;
  always_ff @(posedge clk) begin
    if (!reset_n)                            lb_q <= 1'b0;
    else if (wr_hit && reg_sel == REG_CTRL)  lb_q <= d_data[0];
  end
  assign rx_in   = lb_q ? txd_q : rxd;
  assign ctrl_rd = {31'b0, lb_q};
`else
  assign rx_in   = rxd;
  assign ctrl_rd = '0;
`endif

  // ---------------- RX FSM ----------------
  ser_state_e    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q, rx_half, rx_last;
  logic          ovr_set, fe_set;

  assign rx_half = (rx_cnt_q == CNT_HALF);
  assign rx_last = (rx_cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q    <= rx_in;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      S_IDLE:  if (!rx_s2_q && rx_prev_q) rx_state_d = S_START;
      S_START: if (rx_half) rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      S_DATA:  if (rx_last && rx_bit_q == 3'd7) rx_state_d = S_STOP;
      S_STOP:  if (rx_last) rx_state_d = S_IDLE;
      default: rx_state_d = S_IDLE;
    endcase
  end

  // A full FIFO still accepts the byte when the bus pops in the same cycle.
  always_comb begin
    rx_cnt_d = rx_cnt_q + CNT_ONE;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    ovr_set  = 1'b0;
    fe_set   = 1'b0;
    unique case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
      end
      S_START: if (rx_half) rx_cnt_d = '0;
      S_DATA: if (rx_last) begin
        rx_cnt_d = '0;
        rx_bit_d = rx_bit_q + 3'd1;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
      end
      S_STOP: if (rx_last) begin
        rx_cnt_d = '0;
        if (!rx_s2_q)                  fe_set  = 1'b1;
        else if (rx_full && !rx_pop)   ovr_set = 1'b1;
        else                           rx_push = 1'b1;
      end
      default: rx_cnt_d = '0;
    endcase
  end

  // ---------------- sticky flags ----------------
  logic ovr_q, drop_q, fe_q, ovr_d, drop_d, fe_d, st_clr, drop_set;

  assign st_clr   = wr_hit && (reg_sel == REG_STATUS);
  assign drop_set = wr_hit && (reg_sel == REG_DATA) && tx_full;

  // A set in the same cycle as a clear wins.
  always_comb begin
    ovr_d  = (st_clr ? 1'b0 : ovr_q)  | ovr_set;
    drop_d = (st_clr ? 1'b0 : drop_q) | drop_set;
    fe_d   = (st_clr ? 1'b0 : fe_q)   | fe_set;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovr_q  <= 1'b0;
      drop_q <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      drop_q <= drop_d;
      fe_q   <= fe_d;
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    rd_data = '0;
    unique case (reg_sel)
      REG_DATA:   rd_data = rx_empty ? 32'h0 : {1'b1, 23'b0, rx_head};
      REG_STATUS: rd_data = pack_status(tx_full, tx_empty && (tx_state_q == S_IDLE),
                                        !rx_empty, ovr_q, drop_q, fe_q);
      REG_CTRL:   rd_data = ctrl_rd;
      default:    rd_data = '0;
    endcase
  end

  assign d_data = rd_hit ? rd_data : {32{1'bz}};

endmodule

// File: tb/tb_bus_serial.sv
// Randomized self-checking bench for bus_serial; the reference model works in
// frame timing (start edge per accepted byte) and byte queues, not FSM states.
module tb_bus_serial;
  localparam logic [31:0] BASE = 32'h0000_0020;
  localparam int C = 4;
  localparam int D = 4;
  localparam logic [31:0] FLOAT_PAT = 32'h1234_5600;

  logic        clk = 1'b0, reset_n = 1'b0, strobe = 1'b0, mem_rw = 1'b0, rxd = 1'b1;
  logic [31:0] d_addr = '0, drv = '0;
  logic        drv_en = 1'b0;
  wire  [31:0] d_data;
  logic        txd;

  assign d_data = drv_en ? drv : {32{1'bz}};

  bus_serial #(.BASE(BASE), .CLKDIV(C), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .strobe(strobe), .mem_rw(mem_rw),
    .d_addr(d_addr), .d_data(d_data), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  int tx_s[$];
  logic [7:0] tx_b[$];
  int last_s = -1000;
  logic [7:0] rxq[$];
  logic m_ovr = 1'b0, m_drop = 1'b0, m_fe = 1'b0, m_ctrl = 1'b0;
  bit chk_tx = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bytes still waiting in the TX FIFO just before edge e.
  function automatic int tx_pending(int e);
    int n = 0;
    foreach (tx_s[i]) if (tx_s[i] >= e) n++;
    return n;
  endfunction

  function automatic logic tx_idle(int k);
    foreach (tx_s[i]) if (tx_s[i] + 10*C > k) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_txd(int t);
    int ph;
    foreach (tx_s[i]) begin
      if (t >= tx_s[i] && t < tx_s[i] + 10*C) begin
        ph = (t - tx_s[i]) / C;
        if (ph == 0) return 1'b0;
        if (ph <= 8) return tx_b[i][ph-1];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status(int k);
    return {26'b0, m_fe, m_drop, m_ovr, rxq.size() != 0, tx_idle(k), tx_pending(k+1) >= D};
  endfunction

  always @(negedge clk) if (chk_tx) chk("txd", {31'b0, txd}, {31'b0, exp_txd(cyc)});

  task automatic bus_wr(logic [31:0] a, logic [31:0] v);
    int e, s;
    @(negedge clk);
    strobe = 1'b1; mem_rw = 1'b1; d_addr = a; drv = v; drv_en = 1'b1;
    e = cyc + 1;
    if (a == BASE) begin
      if (tx_pending(e) >= D) m_drop = 1'b1;
      else begin
        s = (e + 1 > last_s + 10*C + 1) ? e + 1 : last_s + 10*C + 1;
        tx_s.push_back(s);
        tx_b.push_back(v[7:0]);
        last_s = s;
      end
    end else if (a == BASE + 32'd1) begin
      m_ovr = 1'b0; m_drop = 1'b0; m_fe = 1'b0;
    end
`ifdef BUS_SERIAL_LOOPBACK_EN
    else if (a == BASE + 32'd2) m_ctrl = v[0];
`endif
    @(posedge clk); #1;
    strobe = 1'b0; mem_rw = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rd_chk(string tag, logic [31:0] a);
    logic [31:0] v, e;
    @(negedge clk);
    strobe = 1'b1; mem_rw = 1'b0; d_addr = a; drv_en = 1'b0;
    if (a == BASE)               e = (rxq.size() != 0) ? {1'b1, 23'b0, rxq[0]} : 32'h0;
    else if (a == BASE + 32'd1)  e = exp_status(cyc);
    else                         e = {31'b0, m_ctrl};
    #1 v = d_data;
    chk(tag, v, e);
    if (a == BASE && rxq.size() != 0) void'(rxq.pop_front());
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  // Another agent drives a pattern; any contribution from the DUT would corrupt it.
  task automatic float_chk(string tag, logic [31:0] a, logic stb);
    @(negedge clk);
    strobe = stb; mem_rw = 1'b0; d_addr = a; drv = FLOAT_PAT; drv_en = 1'b1;
    #1 chk(tag, d_data, FLOAT_PAT);
    @(posedge clk); #1;
    strobe = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rx_frame(logic [7:0] b, logic stop_ok);
    @(negedge clk); rxd = 1'b0; repeat (C-1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rxd = b[i]; repeat (C-1) @(negedge clk);
    end
    @(negedge clk); rxd = stop_ok; repeat (C-1) @(negedge clk);
    @(negedge clk); rxd = 1'b1; repeat (C+6) @(negedge clk);
    if (!stop_ok)            m_fe = 1'b1;
    else if (rxq.size() >= D) m_ovr = 1'b1;
    else                     rxq.push_back(b);
  endtask

  task automatic wait_tx_idle();
    while (!tx_idle(cyc)) @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_txd", {31'b0, txd}, 32'h1);
    reset_n = 1'b1;
    chk_tx = 1'b1;
    rd_chk("rst_status", BASE + 32'd1);
    rd_chk("rst_data", BASE);
    float_chk("idle_float", BASE, 1'b0);
    float_chk("miss_hi", BASE + 32'd3, 1'b1);
    float_chk("miss_lo", BASE - 32'd1, 1'b1);

    bus_wr(BASE, 32'h1A5);
    repeat (3*C) @(negedge clk);
    rd_chk("tx_busy_status", BASE + 32'd1);
    wait_tx_idle();
    rd_chk("tx_done_status", BASE + 32'd1);

    rx_frame(8'h3C, 1'b1);
    rd_chk("rx_status", BASE + 32'd1);
    rd_chk("rx_data", BASE);
    rd_chk("rx_empty", BASE);

    for (int i = 0; i < 6; i++) bus_wr(BASE, 32'($urandom_range(0, 255)));
    rd_chk("drop_status", BASE + 32'd1);
    bus_wr(BASE + 32'd1, 32'h0);
    rd_chk("drop_clear", BASE + 32'd1);
    wait_tx_idle();

    for (int i = 0; i < 5; i++) rx_frame(8'($urandom), 1'b1);
    rx_frame(8'($urandom), 1'b0);
    rd_chk("ovr_fe_status", BASE + 32'd1);
    for (int i = 0; i < 5; i++) rd_chk("ovr_data", BASE);
    bus_wr(BASE + 32'd1, 32'hFFFF_FFFF);
    rd_chk("sticky_clear", BASE + 32'd1);

`ifndef BUS_SERIAL_LOOPBACK_EN
    bus_wr(BASE + 32'd2, 32'h1);
    rd_chk("ctrl_ignored", BASE + 32'd2);
`endif

    // Reset in the middle of a frame with both FIFOs holding data.
    rx_frame(8'h77, 1'b1);
    for (int i = 0; i < 3; i++) bus_wr(BASE, 32'($urandom_range(0, 255)));
    repeat (3*C + 1) @(negedge clk);
    chk_tx = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_txd", {31'b0, txd}, 32'h1);
    reset_n = 1'b1;
    tx_s.delete(); tx_b.delete(); last_s = -1000; rxq.delete();
    m_ovr = 1'b0; m_drop = 1'b0; m_fe = 1'b0; m_ctrl = 1'b0;
    chk_tx = 1'b1;
    rd_chk("midrst_status", BASE + 32'd1);
    rd_chk("midrst_data", BASE);

    repeat (300) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3: bus_wr(BASE, $urandom);
        4:          rd_chk("rnd_status", BASE + 32'd1);
        5, 6:       rd_chk("rnd_data", BASE);
        7:          bus_wr(BASE + 32'd1, $urandom);
        8:          repeat ($urandom_range(1, 40)) @(negedge clk);
        9:          rx_frame(8'($urandom), $urandom_range(0, 5) != 0);
        10:         rd_chk("rnd_ctrl", BASE + 32'd2);
        default:    float_chk("rnd_miss", BASE + 32'(3 + $urandom_range(0, 3)), 1'b1);
      endcase
    end

`ifdef BUS_SERIAL_LOOPBACK_EN
    wait_tx_idle();
    while (rxq.size() != 0) rd_chk("lb_drain", BASE);
    bus_wr(BASE + 32'd1, 32'h0);
    bus_wr(BASE + 32'd2, 32'h1);
    rd_chk("lb_ctrl", BASE + 32'd2);
    rxd = 1'b0;
    bus_wr(BASE, 32'h5A);
    wait_tx_idle();
    repeat (10) @(negedge clk);
    rxq.push_back(8'h5A);
    rd_chk("lb_status", BASE + 32'd1);
    rd_chk("lb_data", BASE);
    rxd = 1'b1;
    bus_wr(BASE + 32'd2, 32'h0);
    rd_chk("lb_ctrl_off", BASE + 32'd2);
`endif

    wait_tx_idle();
    rd_chk("final_status", BASE + 32'd1);
    chk_tx = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
